// File: rtl/sensor_bounce_gen.sv
// sensor_bounce_gen: drives a bouncing sensor line toward a requested level so
// that debounce timing downstream can be exercised. Each transition issues
// 2*BOUNCE_PAIRS+1 toggles separated by segments of L cycles, then holds the
// line stable for HOLD_CYC cycles before pulsing done.
//
// Optional feature macro: SENSOR_BOUNCE_LFSR_EN
//   defined   -> segment length L = LFSR[log2(BOUNCE_MAX_CYC)-1:0] + 1 (1..BOUNCE_MAX_CYC)
//   undefined -> every segment is BOUNCE_MAX_CYC cycles, no LFSR is built
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line stable, waiting for start
// S_BOUNCE | issuing toggles, segment counter running
// S_HOLD   | final level reached, holding for HOLD_CYC cycles
// S_DONE   | one-cycle completion pulse, start ignored
module sensor_bounce_gen #(
  parameter int          BOUNCE_PAIRS   = 2,
  parameter int          BOUNCE_MAX_CYC = 8,
  parameter int          HOLD_CYC       = 20,
  parameter logic        INIT_LEVEL     = 1'b0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       level_req,
  output logic       sensor_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] edge_cnt
);

  localparam int TOGGLES = 2 * BOUNCE_PAIRS + 1;
  localparam int REM_W   = $clog2(TOGGLES + 1);
  // one extra bit so BOUNCE_MAX_CYC itself fits in the segment counter
  localparam int SEG_W   = $clog2(BOUNCE_MAX_CYC) + 1;
  localparam int HOLD_W  = $clog2(HOLD_CYC + 2);

  localparam logic [REM_W-1:0]  TOGGLES_V = REM_W'(TOGGLES);
  localparam logic [SEG_W-1:0]  SEG_MAX   = SEG_W'(BOUNCE_MAX_CYC);
  localparam logic [HOLD_W-1:0] HOLD_V    = HOLD_W'(HOLD_CYC);

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              sensor_q;
  logic              target_q;
  logic [7:0]        edge_q;
  logic [REM_W-1:0]  rem_q;
  logic [SEG_W-1:0]  seg_q;
  logic [HOLD_W-1:0] hold_q;
  logic [SEG_W-1:0]  seg_len;
  logic              toggle;
  logic              clear_cnt;

`ifdef SENSOR_BOUNCE_LFSR_EN
  localparam int          IDX_W     = $clog2(BOUNCE_MAX_CYC);
  localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr;

  // free-running Galois LFSR; a non-zero state can never shift into zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= LFSR_INIT;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ 16'hB400;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  assign seg_len = {1'b0, lfsr[IDX_W-1:0]} + SEG_W'(1);
`else
  assign seg_len = SEG_MAX;
`endif

  // next-state decode plus toggle/clear strobes and status outputs
  always_comb begin
    state_d   = state_q;
    toggle    = 1'b0;
    clear_cnt = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear_cnt = 1'b1;
          if (level_req != sensor_q) begin
            toggle  = 1'b1;
            state_d = (TOGGLES == 1) ? S_HOLD : S_BOUNCE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_BOUNCE: begin
        busy = 1'b1;
        if (seg_q == SEG_W'(1)) begin
          toggle = 1'b1;
          if (rem_q == REM_W'(1)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        busy = 1'b1;
        if (hold_q <= HOLD_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register and transition datapath (line, counters, target)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sensor_q <= INIT_LEVEL;
      target_q <= 1'b0;
      edge_q   <= 8'd0;
      rem_q    <= '0;
      seg_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && start) target_q <= level_req;

      // the last toggle lands on the latched target by construction; forcing
      // it keeps the final level correct even if the toggle count were even
      if (toggle) begin
        if (state_q == S_BOUNCE && rem_q == REM_W'(1)) sensor_q <= target_q;
        else                                          sensor_q <= ~sensor_q;
        seg_q <= seg_len;
      end else if (state_q == S_BOUNCE) begin
        seg_q <= seg_q - SEG_W'(1);
      end

      if (clear_cnt)                         edge_q <= {7'd0, toggle};
      else if (toggle && edge_q != 8'hFF)    edge_q <= edge_q + 8'd1;

      if (clear_cnt)   rem_q <= TOGGLES_V - REM_W'(1);
      else if (toggle) rem_q <= rem_q - REM_W'(1);

      if (state_d == S_HOLD && state_q != S_HOLD) hold_q <= HOLD_V;
      else if (state_q == S_HOLD)                 hold_q <= hold_q - HOLD_W'(1);
    end
  end

  assign sensor_out = sensor_q;
  assign edge_cnt   = edge_q;

endmodule

// File: tb/tb_sensor_bounce_gen.sv
// Directed bench for sensor_bounce_gen. Default build checks exact toggle,
// busy and done timing cycle by cycle; with SENSOR_BOUNCE_LFSR_EN defined it
// runs 200 alternating transitions and checks segment bounds instead.
module tb_sensor_bounce_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       level_req;
  logic       sensor_out;
  logic       busy;
  logic       done;
  logic [7:0] edge_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sensor_bounce_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .level_req  (level_req),
    .sensor_out (sensor_out),
    .busy       (busy),
    .done       (done),
    .edge_cnt   (edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b0;
    start     = 1'b1;   // coincident with reset, must be discarded
    level_req = 1'b1;
    tick;
    tick;
    chk("rst_sensor", 32'(sensor_out), 0);
    chk("rst_busy",   32'(busy),       0);
    chk("rst_done",   32'(done),       0);
    chk("rst_edge",   32'(edge_cnt),   0);
    reset = 1'b1;
    start = 1'b0;
    tick;
    chk("post_rst_sensor", 32'(sensor_out), 0);
    chk("post_rst_busy",   32'(busy),       0);
  endtask

`ifndef SENSOR_BOUNCE_LFSR_EN
  // Start a transition to lvl from idle level init, then check 60 cycles.
  // Toggles expected at t+1,9,17,25,33; done at t+53. poke_k issues a start
  // that must be ignored; rst_k asserts reset during that cycle.
  task automatic run_trans(input logic lvl, input logic init, input int poke_k, input int rst_k);
    int   n;
    logic exp_s, exp_b, exp_d;
    int   exp_e;
    level_req = lvl;
    start     = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick;
      start = 1'b0;
      reset = 1'b1;
      n = 0;
      for (int j = 0; j < 5; j++) if (1 + 8 * j <= k) n++;
      if (rst_k >= 0 && k > rst_k) begin
        exp_s = 1'b0; exp_b = 1'b0; exp_d = 1'b0; exp_e = 0;
      end else begin
        exp_s = init ^ n[0];
        exp_b = (k < 53);
        exp_d = (k == 53);
        exp_e = n;
      end
      chk($sformatf("sensor_out@t+%0d", k), 32'(sensor_out), 32'(exp_s));
      chk($sformatf("busy@t+%0d", k),       32'(busy),       32'(exp_b));
      chk($sformatf("done@t+%0d", k),       32'(done),       32'(exp_d));
      chk($sformatf("edge_cnt@t+%0d", k),   32'(edge_cnt),   exp_e);
      if (k == poke_k) begin
        start     = 1'b1;
        level_req = ~lvl;
      end
      if (k == rst_k) reset = 1'b0;
    end
  endtask

  initial begin
    do_reset;
    // 0 -> 1, with a start during the DONE cycle that must be ignored
    run_trans(1'b1, 1'b0, 53, -1);
    // already at 1, request 1: immediate done, no toggle, edge_cnt cleared
    level_req = 1'b1;
    start     = 1'b1;
    tick;
    start = 1'b0;
    chk("same_done",   32'(done),       1);
    chk("same_busy",   32'(busy),       0);
    chk("same_edge",   32'(edge_cnt),   0);
    chk("same_sensor", 32'(sensor_out), 1);
    tick;
    chk("same_done_end", 32'(done),       0);
    chk("same_sensor2",  32'(sensor_out), 1);
    // 1 -> 0 with an ignored start mid-bounce
    run_trans(1'b0, 1'b1, 10, -1);
    // 0 -> 1 aborted by reset during t+12
    run_trans(1'b1, 1'b0, -1, 12);
    // normal transition after the abort
    run_trans(1'b1, 1'b0, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
`else
  initial begin
    logic lvl, prev;
    int   k, last, tog;
    do_reset;
    for (int i = 0; i < 200; i++) begin
      lvl       = ~sensor_out;
      level_req = lvl;
      start     = 1'b1;
      tick;
      start = 1'b0;
      k     = 1;
      last  = 1;
      tog   = 1;
      prev  = sensor_out;
      chk("first_toggle", 32'(sensor_out), 32'(lvl));
      while (!done && k < 400) begin
        tick;
        k++;
        chk("lfsr_nonzero", 32'(dut.lfsr != 16'h0000), 1);
        if (sensor_out != prev) begin
          chk("seg_len_in_range", 32'((k - last) >= 1 && (k - last) <= 8), 1);
          last = k;
          tog++;
          prev = sensor_out;
        end
      end
      chk("done_seen",     32'(done),       1);
      chk("hold_cycles",   k - last,        20);
      chk("toggle_count",  tog,             5);
      chk("edge_cnt",      32'(edge_cnt),   5);
      chk("final_level",   32'(sensor_out), 32'(lvl));
      tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
`endif

endmodule

// File: doc/sensor_bounce_gen.md
SENSOR_BOUNCE_GEN -- requirements
Module: sensor_bounce_gen

Purpose: drives a bouncing sensor line into the sensor debouncer input so debounce timing can be exercised.

Interface
REQ-001 Parameter BOUNCE_PAIRS, default 2: number of extra toggle pairs per transition; total toggles per transition SHALL be 2*BOUNCE_PAIRS+1.
REQ-002 Parameter BOUNCE_MAX_CYC, default 8, power of two, at least 2: maximum bounce segment length in cycles.
REQ-003 Parameter HOLD_CYC, default 20: stable cycles after the final toggle before completion.
REQ-004 Parameter INIT_LEVEL, default 0: sensor_out level after reset.
REQ-005 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to drive sensor_out toward level_req.
REQ-009 level_req  input  1  target level, sampled only when start is accepted.
REQ-010 sensor_out  output  1  bouncing line to the debouncer sensor_in; registered.
REQ-011 busy  output  1  high while a transition is in progress.
REQ-012 done  output  1  one-cycle pulse at completion.
REQ-013 edge_cnt  output  8  toggles issued since the last accepted start; saturates at 255.

Function
REQ-014 States: IDLE, BOUNCE, HOLD, DONE.
REQ-015 IDLE: sensor_out holds; busy=0; done=0.
REQ-016 start=1 in IDLE with level_req != sensor_out:
  - latch the target;
  - clear edge_cnt, load remaining-toggle counter with 2*BOUNCE_PAIRS+1;
  - enter BOUNCE and toggle sensor_out on the same edge (first toggle visible at t+1);
  - busy=1 from t+1.
REQ-017 start=1 in IDLE with level_req == sensor_out:
  - no toggle; edge_cnt cleared;
  - enter DONE (done=1 at t+1).
REQ-018 start while busy=1 SHALL be ignored; level_req is not resampled.
REQ-019 BOUNCE segment handling:
  - each toggle loads a segment counter with length L;
  - the next toggle occurs exactly L cycles later;
  - each toggle increments edge_cnt and decrements the remaining count.
REQ-020 When the remaining count reaches 0, sensor_out SHALL equal the latched target; the state becomes HOLD.
REQ-021 HOLD: sensor_out stable for HOLD_CYC cycles; done=1 exactly HOLD_CYC cycles after the final toggle; busy falls on that same edge.
REQ-022 DONE: done high for one cycle, then IDLE; start in that cycle is ignored.
REQ-023 LFSR: 16-bit Galois, taps mask 16'hB400.
  - Advances every cycle outside reset, independent of state.
  - SHALL never hold 0.
REQ-024 Segment length L SHALL be in the range 1..BOUNCE_MAX_CYC; width arithmetic must not overflow at BOUNCE_MAX_CYC.

Reset
REQ-025 reset=0 at a rising edge SHALL set:
  - sensor_out=INIT_LEVEL, busy=0, done=0, edge_cnt=0;
  - state=IDLE, LFSR=seed, all counters 0.
REQ-026 Reset mid-BOUNCE or mid-HOLD SHALL abort the transition with no done pulse.
REQ-027 A start coincident with reset=0 SHALL be discarded.

Configuration
REQ-028 Macro SENSOR_BOUNCE_LFSR_EN:
  - Defined: L = LFSR[log2(BOUNCE_MAX_CYC)-1:0] + 1, sampled at each toggle.
  - Undefined: every L = BOUNCE_MAX_CYC, the LFSR is not instantiated, and the output is fully deterministic.

Verification (defaults; macro undefined unless stated)
REQ-029 Hold reset=0 for 2 cycles -> sensor_out=0, busy=0, done=0, edge_cnt=0.
REQ-030 Idle at 0; start=1 with level_req=1 at cycle t ->
  - sensor_out toggles at t+1, t+9, t+17, t+25, t+33;
  - final sensor_out=1;
  - done=1 only at t+53; busy low from t+53;
  - edge_cnt=5.
REQ-031 Idle at 1; start=1 with level_req=1 -> no toggle, done=1 at t+1, edge_cnt=0, busy stays 0.
REQ-032 Transition from REQ-030 running; at t+10 pulse start with level_req=0 -> ignored; timing and values identical to REQ-030.
REQ-033 Transition running; reset=0 at t+12 -> at t+13 sensor_out=0, busy=0, edge_cnt=0; no done pulse ever.
REQ-034 Macro defined, seed 16'hACE1; 200 alternating transitions ->
  - every segment length in 1..8;
  - edge_cnt=5 per transition;
  - final level matches level_req;
  - done exactly 20 cycles after the last toggle;
  - LFSR never 0.
